// File: rtl/iob_modcnt_down_timer_pkg.sv
// Shared definitions for the modulo down-timer: FSM state encoding.
package iob_modcnt_down_timer_pkg;

    localparam int STATE_W = 1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/iob_counter_sat.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module iob_counter_sat #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] data_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // Clear wins over increment so a restart always begins the tally from zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o <= '0;
        end else if (clr_i) begin
            data_o <= '0;
        end else if (en_i && (data_o != MAX_VAL)) begin
            data_o <= data_o + ONE;
        end
    end

endmodule

// File: rtl/iob_modcnt_down_timer.sv
// Loadable modulo down-timer: counts a programmed tick budget down to zero,
// pulsing tc_o at each terminal count, in periodic or one-shot mode.
module iob_modcnt_down_timer
    import iob_modcnt_down_timer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int WRAP_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              oneshot_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] mod_i,
    output logic [DATA_W-1:0] data_o,
    output logic              tc_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [WRAP_W-1:0] wraps_o
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    state_t            state_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mod_q;
    logic              oneshot_q;
    logic              tc_q;
    logic              err_q;

    logic              mod_zero;
    logic              load_ok;
    logic              terminal;

    assign mod_zero = (mod_i == '0);
    assign load_ok  = !stop_i && start_i && !mod_zero;
    // Terminal tick only when no stop or start (accepted or rejected) claims the cycle.
    assign terminal = !stop_i && !start_i && (state_q == ST_RUN) && en_i && (data_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            mod_q     <= '0;
            oneshot_q <= 1'b0;
            tc_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            tc_q  <= 1'b0;
            err_q <= 1'b0;
            if (stop_i) begin
                state_q <= ST_IDLE;
            end else if (start_i) begin
                if (mod_zero) begin
                    err_q <= 1'b1;
                end else begin
                    state_q   <= ST_RUN;
                    data_q    <= mod_i - ONE;
                    mod_q     <= mod_i;
                    oneshot_q <= oneshot_i;
                end
            end else if ((state_q == ST_RUN) && en_i) begin
                if (data_q != '0) begin
                    data_q <= data_q - ONE;
                end else begin
                    tc_q <= 1'b1;
                    if (oneshot_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        data_q <= mod_q - ONE;
                    end
                end
            end
        end
    end

    iob_counter_sat #(
        .WIDTH (WRAP_W)
    ) u_wraps (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (load_ok),
        .en_i   (terminal),
        .data_o (wraps_o)
    );

    assign data_o = data_q;
    assign tc_o   = tc_q;
    assign err_o  = err_q;
    assign busy_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_iob_modcnt_down_timer.sv
// Self-checking bench for iob_modcnt_down_timer: directed scenarios then random
// traffic, each cycle compared against a tick-budget reference model.
module tb_iob_modcnt_down_timer;

    localparam int DATA_W    = 8;
    localparam int WRAP_W    = 2;
    localparam int TALLY_MAX = (1 << WRAP_W) - 1;

    logic              clk_i;
    logic              rst_i;
    logic              start_i;
    logic              stop_i;
    logic              oneshot_i;
    logic              en_i;
    logic [DATA_W-1:0] mod_i;
    logic [DATA_W-1:0] data_o;
    logic              tc_o;
    logic              busy_o;
    logic              err_o;
    logic [WRAP_W-1:0] wraps_o;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining budget, programmed period, mode and tally as plain integers.
    bit m_running;
    bit m_once;
    int m_budget;
    int m_period;
    int m_tally;
    bit m_tc;
    bit m_err;

    iob_modcnt_down_timer #(
        .DATA_W (DATA_W),
        .WRAP_W (WRAP_W)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .oneshot_i (oneshot_i),
        .en_i      (en_i),
        .mod_i     (mod_i),
        .data_o    (data_o),
        .tc_o      (tc_o),
        .busy_o    (busy_o),
        .err_o     (err_o),
        .wraps_o   (wraps_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic modelStep(input bit r, input bit s, input bit p, input bit o,
                             input bit e, input int m);
        m_tc  = 1'b0;
        m_err = 1'b0;
        if (r) begin
            m_running = 1'b0;
            m_once    = 1'b0;
            m_budget  = 0;
            m_period  = 0;
            m_tally   = 0;
        end else if (p) begin
            m_running = 1'b0;
        end else if (s) begin
            if (m == 0) begin
                m_err = 1'b1;
            end else begin
                m_running = 1'b1;
                m_period  = m;
                m_budget  = m - 1;
                m_once    = o;
                m_tally   = 0;
            end
        end else if (m_running && e) begin
            if (m_budget > 0) begin
                m_budget = m_budget - 1;
            end else begin
                m_tc    = 1'b1;
                m_tally = (m_tally < TALLY_MAX) ? m_tally + 1 : TALLY_MAX;
                if (m_once) m_running = 1'b0;
                else        m_budget  = m_period - 1;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [DATA_W-1:0] exp_data;
        logic [WRAP_W-1:0] exp_wraps;
        exp_data  = DATA_W'(m_budget);
        exp_wraps = WRAP_W'(m_tally);
        checks++;
        assert (data_o === exp_data) else begin
            errors++;
            $error("[TB] FAIL %s data_o got %0d expected %0d", tag, data_o, exp_data);
        end
        checks++;
        assert (tc_o === m_tc) else begin
            errors++;
            $error("[TB] FAIL %s tc_o got %0b expected %0b", tag, tc_o, m_tc);
        end
        checks++;
        assert (busy_o === m_running) else begin
            errors++;
            $error("[TB] FAIL %s busy_o got %0b expected %0b", tag, busy_o, m_running);
        end
        checks++;
        assert (err_o === m_err) else begin
            errors++;
            $error("[TB] FAIL %s err_o got %0b expected %0b", tag, err_o, m_err);
        end
        checks++;
        assert (wraps_o === exp_wraps) else begin
            errors++;
            $error("[TB] FAIL %s wraps_o got %0d expected %0d", tag, wraps_o, exp_wraps);
        end
    endtask

    // Drives one cycle of inputs, advances the model at the edge, checks #1 after it.
    task automatic applyStimulus(input bit r, input bit s, input bit p, input bit o,
                                 input bit e, input int m, input string tag);
        rst_i     = r;
        start_i   = s;
        stop_i    = p;
        oneshot_i = o;
        en_i      = e;
        mod_i     = DATA_W'(m);
        @(posedge clk_i);
        modelStep(r, s, p, o, e, m);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
        oneshot_i = 1'b0; en_i = 1'b0; mod_i = '0;
        #1;

        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 1, 5, "reset");

        applyStimulus(0, 1, 0, 0, 0, 4, "per_start");
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 1, 0, "per_tick");

        applyStimulus(0, 1, 0, 1, 0, 3, "os_start");
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, (i % 2) == 1, 0, "os_tick");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, "os_after");

        applyStimulus(0, 1, 0, 0, 0, 2, "stop_start");
        applyStimulus(0, 0, 0, 0, 1, 0, "stop_tick");
        applyStimulus(0, 0, 1, 0, 1, 0, "stop_at0");
        applyStimulus(0, 0, 0, 0, 1, 0, "stop_idle");
        applyStimulus(0, 1, 0, 0, 0, 0, "err_mod0");
        applyStimulus(0, 0, 0, 0, 0, 0, "err_clear");

        applyStimulus(0, 1, 0, 0, 0, 10, "rs_start");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, "rs_tick");
        applyStimulus(0, 1, 0, 0, 1, 2, "rs_restart");
        applyStimulus(0, 1, 0, 0, 1, 0, "rs_reject");

        applyStimulus(0, 1, 0, 0, 0, 1, "sat_start");
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1, 0, "sat_tick");

        applyStimulus(0, 1, 0, 0, 0, 255, "max_mod");
        applyStimulus(0, 0, 0, 0, 1, 0, "max_tick");
        applyStimulus(0, 1, 1, 0, 1, 0, "stop_over_start");

        for (int i = 0; i < 400; i++) begin
            bit r, s, p, o, e;
            int m;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 8);
            p = ($urandom_range(0, 99) < 4);
            o = $urandom_range(0, 1) == 1;
            e = ($urandom_range(0, 99) < 70);
            m = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 6));
            applyStimulus(r, s, p, o, e, m, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_modcnt_down_timer.md
Name: iob_modcnt_down_timer

Overview:
Loadable modulo down-counter: counts mod-1 down to 0 on each enable tick, then flags terminal count. It is the counterpart of the team's modulo up-counters: the up-counter measures elapsed ticks, this block consumes a programmed tick budget. Runs periodic (auto-reload) or one-shot, with start/stop control and a saturating terminal-count tally. Used as a programmable timer/tick divider in peripheral cores.

Parameters:
DATA_W, 32, width of modulus and count value
WRAP_W, 8, width of terminal-count tally (saturating)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  load mod_i and begin counting (restart if running)
stop_i  input  1  abort counting, hold current value
oneshot_i  input  1  sampled with start_i: 1=one-shot, 0=periodic
en_i  input  1  count tick; decrement only when high and running
mod_i  input  DATA_W  modulus, sampled with start_i
data_o  output  DATA_W  current count value
tc_o  output  1  one-cycle terminal-count pulse
busy_o  output  1  high while in RUN
err_o  output  1  one-cycle pulse: start_i with mod_i==0 rejected
wraps_o  output  WRAP_W  number of terminal counts since last start, saturating

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset: state=IDLE, data_o=0, tc_o=0, busy_o=0, err_o=0, wraps_o=0, mod_q=0, oneshot_q=0. Reset overrides all inputs.
- FSM states: IDLE, RUN. busy_o = (state==RUN), registered.
- Priority per cycle: rst_i > stop_i > start_i > en_i.
- IDLE + start_i, mod_i!=0: next cycle state=RUN, data_o=mod_i-1, mod_q=mod_i, oneshot_q=oneshot_i, wraps_o=0.
- Any state + start_i with mod_i==0: err_o=1 next cycle; state, data_o, wraps_o unchanged.
- RUN + start_i (mod_i!=0): restart exactly as from IDLE; a same-cycle en_i is ignored, no tc_o.
- RUN + stop_i: next cycle state=IDLE, data_o holds, no tc_o even if data_o==0 and en_i=1.
- RUN + en_i, data_o!=0: data_o decrements by 1 next cycle.
- RUN + en_i, data_o==0: tc_o=1 next cycle (one cycle only); wraps_o increments, saturates at 2^WRAP_W-1.
  - periodic: data_o reloads mod_q-1, stay RUN.
  - one-shot: data_o stays 0, state=IDLE.
- RUN, en_i=0: all state held; tc_o=0.
- IDLE ignores en_i; data_o holds last value.
- mod=1: data_o stays 0; every en_i in RUN yields tc_o (periodic).
- Latency: start_i at cycle N -> busy_o/data_o valid at N+1; first decrement visible at N+2 if en_i at N+1. Terminal pulse one cycle after the consuming en_i.
- Subtraction mod_i-1 in DATA_W bits; mod_i=2^DATA_W-1 loads 2^DATA_W-2. No wrap below 0: reload/stop occurs instead.
- tc_o, err_o are registered and deasserted in every cycle that does not meet their conditions.

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, RUN=1'b1) and state width constant.
- One sub-module: iob_counter_sat (WRAP_W-bit up-counter with synchronous clear, enable, saturation at all-ones) for wraps_o. Down-counter and FSM stay in top.

Test Plan:
- Reset with start_i=1, mod_i=5 held -> data_o=0, busy_o=0, tc_o=0, wraps_o=0 for all reset cycles.
- Periodic mod_i=4, en_i always 1 -> data_o 3,2,1,0,3,2,1,0...; tc_o pulses every 4th cycle, coincident with data_o=3 reload; wraps_o 1,2,3 after 12 ticks.
- One-shot mod_i=3, en_i every other cycle -> data_o 2,2,1,1,0,0 then tc_o once, busy_o=0, data_o holds 0, wraps_o=1; further en_i no change.
- stop_i while data_o=0 with en_i=1 -> no tc_o, busy_o=0 next cycle, data_o=0 held; start_i mod_i=0 -> err_o single pulse, busy_o stays 0.
- Restart mid-run: mod_i=10 running at data_o=6, start_i with mod_i=2 and en_i=1 -> data_o=1, wraps_o=0, no tc_o; mod_i=1 periodic -> tc_o every en_i.
- WRAP_W=2, mod_i=1 periodic, 6 ticks -> wraps_o 1,2,3,3,3,3 (saturated).
